hdmi_capture_ctrl: RTL
======================

Name: hdmi_capture_ctrl

Overview:
- Sequences capture of a rectangular window from the decoded HDMI pixel stream into the downstream pixel FIFO.
- Arms on a start command and waits for a stable link and the start of a frame.
- Gates the FIFO write enable so only pixels inside the configured window are written.
- Reports frame completion, overflow and sync loss; single-shot and continuous modes.

Parameters:
X_W, 12, width of horizontal pixel coordinates and window config
Y_W, 12, width of line coordinates and window config
DATA_W, 24, pixel width ({red, green, blue})

Ports:
clk  in  1  regenerated pixel clock
reset  in  1  synchronous active-high reset
cfg_x_off  in  X_W  first captured pixel in line
cfg_y_off  in  Y_W  first captured line in frame
cfg_width  in  X_W  pixels per captured line
cfg_height  in  Y_W  captured lines
start  in  1  arm pulse; latches cfg_* and mode
continuous  in  1  1 = re-arm after each frame
abort  in  1  return to idle
hdmi_ready  in  1  AND of all channel ready/valid flags
vsync  in  1  decoded vsync
de  in  1  decoded data enable
pix_data  in  DATA_W  decoded pixel
fifo_full  in  1  downstream FIFO full
fifo_data  out  DATA_W  registered pixel to FIFO
fifo_wr_en  out  1  FIFO write strobe
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after last window pixel written
overflow  out  1  sticky: window pixel dropped on fifo_full
sync_lost  out  1  sticky: hdmi_ready fell while armed
frame_count  out  16  completed frames since start, wraps

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. All outputs registered; reset values: fifo_data 0, fifo_wr_en 0, busy 0, frame_done 0, overflow 0, sync_lost 0, frame_count 0, state IDLE.
- States: IDLE, WAIT_READY, WAIT_FRAME, CAPTURE, DONE.
- IDLE:
  - On start with cfg_width != 0 and cfg_height != 0: latch cfg_* and continuous, clear overflow, sync_lost and frame_count, go to WAIT_READY.
  - Start with a zero dimension is ignored.
- WAIT_READY: go to WAIT_FRAME when hdmi_ready = 1.
- WAIT_FRAME: go to CAPTURE on the vsync rising edge (vsync = 1, vsync_q = 0). Clear x_cnt and y_cnt.
- CAPTURE counters:
  - x_cnt increments on each de = 1 cycle and clears on de falling edge.
  - y_cnt increments on de falling edge.
  - Both saturate at all-ones.
- In-window test: x_off <= x_cnt < x_off + width and y_off <= y_cnt < y_off + height.
  - Sums computed at X_W+1 / Y_W+1 bits, so a window exceeding the coordinate range never wraps.
- Write path, latency 1: when de = 1 and in-window, the next cycle fifo_data = pix_data and fifo_wr_en = !fifo_full. If fifo_full = 1, no write and overflow is set.
  - fifo_data holds its value when no write occurs.
- Last window pixel (x = x_off+width-1, y = y_off+height-1, de = 1): go to DONE. That pixel's write occurs in the DONE cycle.
- DONE:
  - frame_done = 1 for one cycle; frame_count += 1.
  - Next state is WAIT_FRAME if continuous is latched, otherwise IDLE.
- A vsync rising edge in CAPTURE before the window completes restarts the counters and stays in CAPTURE; the partial frame is not counted.
- hdmi_ready = 0 in WAIT_FRAME, CAPTURE or DONE: set sync_lost, force fifo_wr_en = 0 next cycle, go to WAIT_READY.
- abort has priority over all other events: next state IDLE, fifo_wr_en 0 next cycle. Sticky flags and frame_count are kept.
- start while busy is ignored. Changes to cfg_* while busy have no effect until the next start.
- Reset mid-frame: immediate return to reset values; no partial write.

Optional Feature:
- Macro HDMI_CAPTURE_DECIMATE_EN.
- Defined: adds input cfg_decimate [1:0], latched at start. Only pixels with x_cnt[d-1:0] == 0 and lines with y_cnt[d-1:0] == 0 (d = cfg_decimate, d = 0 means every pixel) are written inside the window.
  - The last-pixel/done condition is unchanged: geometric window end.
- Not defined: no port; every in-window pixel is written.

Decomposition:
- Package hdmi_capture_pkg: state encoding constants, DATA_W default, frame_count width.
- One sub-module, hdmi_window_cnt: x/y counters, edge detect and in-window/last-pixel compare. The FSM and write path stay in the top.

Test Plan:
- Window x_off=2, y_off=1, width=4, height=2; 8 px × 4 lines, single shot, pixel value = {y,x}.
  - Exactly 8 writes: (1,2)..(1,5), (2,2)..(2,5), each 1 cycle after its de cycle.
  - frame_done one pulse; frame_count=1; busy returns to 0.
- Continuous, width=height=2 over 3 frames → 12 writes, 3 frame_done pulses, frame_count=3, busy stays 1.
- fifo_full held high for the 2nd in-window pixel → that write is suppressed, overflow=1, remaining 7 pixels written; the next start clears overflow.
- hdmi_ready dropped mid-CAPTURE → sync_lost=1, fifo_wr_en=0 next cycle, state WAIT_READY. Ready restored → capture resumes at the next vsync rising edge.
- abort in CAPTURE together with start → IDLE, no further writes, start ignored. start with cfg_width=0 → stays IDLE.
- With HDMI_CAPTURE_DECIMATE_EN, cfg_decimate=1, window 4×2 at origin → writes at x=0,2 on line 0 only (2 writes); frame_done still pulses.

Source files
------------

// File: rtl/hdmi_capture_pkg.sv
// Shared constants for the HDMI window capture controller: FSM encoding,
// default pixel width, frame counter width and the decimation mask helper.
package hdmi_capture_pkg;

    localparam int DATA_W_DEF  = 24;
    localparam int FRAME_CNT_W = 16;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_READY = 3'd1;
    localparam logic [2:0] ST_WAIT_FRAME = 3'd2;
    localparam logic [2:0] ST_CAPTURE    = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    // Low coordinate bits that must be zero for a pixel/line to survive decimation.
    function automatic logic [2:0] dec_mask(input logic [1:0] d);
        logic [2:0] m;
        case (d)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            2'd3:    m = 3'b111;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/hdmi_capture_ctrl_if.sv
// Pixel FIFO write port: the controller is master, the FIFO is slave.
interface hdmi_capture_ctrl_if
    import hdmi_capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_wr_en;
    logic              fifo_full;

    modport master (output fifo_data, output fifo_wr_en, input fifo_full);
    modport slave  (input fifo_data, input fifo_wr_en, output fifo_full);
endinterface

// File: rtl/hdmi_capture_ctrl_window_cnt.sv
// Raster position counters with vsync/de edge detection and the window,
// decimation and last-pixel compares used by the capture FSM.
module hdmi_window_cnt
    import hdmi_capture_pkg::*;
#(
    parameter int X_W = 12,
    parameter int Y_W = 12
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_clr,
    input  logic           i_de,
    input  logic           i_vsync,
    input  logic [X_W-1:0] i_x_off,
    input  logic [Y_W-1:0] i_y_off,
    input  logic [X_W-1:0] i_width,
    input  logic [Y_W-1:0] i_height,
    input  logic [1:0]     i_dec,
    output logic           o_vsync_rise,
    output logic           o_wr_sel,
    output logic           o_last_px
);
    logic           r_vsync_q;
    logic           r_de_q;
    logic [X_W-1:0] r_x_cnt;
    logic [Y_W-1:0] r_y_cnt;
    logic [X_W:0]   w_x_end;
    logic [Y_W:0]   w_y_end;
    logic           w_x_in;
    logic           w_y_in;
    logic [2:0]     w_mask;
    logic           w_dec_ok;

    // Edge history and saturating raster counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vsync_q <= 1'b0;
            r_de_q    <= 1'b0;
            r_x_cnt   <= '0;
            r_y_cnt   <= '0;
        end else begin
            r_vsync_q <= i_vsync;
            r_de_q    <= i_de;
            if (i_clr) begin
                r_x_cnt <= '0;
                r_y_cnt <= '0;
            end else if (i_de) begin
                if (r_x_cnt != '1) r_x_cnt <= r_x_cnt + X_W'(1);
            end else if (r_de_q) begin
                r_x_cnt <= '0;
                if (r_y_cnt != '1) r_y_cnt <= r_y_cnt + Y_W'(1);
            end
        end
    end

    // Window ends are one bit wider so an oversized window cannot wrap.
    assign w_x_end      = {1'b0, i_x_off} + {1'b0, i_width};
    assign w_y_end      = {1'b0, i_y_off} + {1'b0, i_height};
    assign w_x_in       = (r_x_cnt >= i_x_off) && ({1'b0, r_x_cnt} < w_x_end);
    assign w_y_in       = (r_y_cnt >= i_y_off) && ({1'b0, r_y_cnt} < w_y_end);
    assign w_mask       = dec_mask(i_dec);
    assign w_dec_ok     = ((r_x_cnt[2:0] & w_mask) == 3'b000) && ((r_y_cnt[2:0] & w_mask) == 3'b000);
    assign o_vsync_rise = i_vsync && !r_vsync_q;
    assign o_wr_sel     = i_de && w_x_in && w_y_in && w_dec_ok;
    assign o_last_px    = i_de && (({1'b0, r_x_cnt} + (X_W+1)'(1)) == w_x_end)
                               && (({1'b0, r_y_cnt} + (Y_W+1)'(1)) == w_y_end);
endmodule

// File: rtl/hdmi_capture_ctrl.sv
// HDMI window capture controller: arms on start, gates window pixels into the FIFO.
// Optional macro HDMI_CAPTURE_DECIMATE_EN adds the i_cfg_decimate port.
module hdmi_capture_ctrl
    import hdmi_capture_pkg::*;
#(
    parameter int X_W    = 12,
    parameter int Y_W    = 12,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [X_W-1:0]         i_cfg_x_off,
    input  logic [Y_W-1:0]         i_cfg_y_off,
    input  logic [X_W-1:0]         i_cfg_width,
    input  logic [Y_W-1:0]         i_cfg_height,
    input  logic                   i_start,
    input  logic                   i_continuous,
    input  logic                   i_abort,
    input  logic                   i_hdmi_ready,
    input  logic                   i_vsync,
    input  logic                   i_de,
    input  logic [DATA_W-1:0]      i_pix_data,
`ifdef HDMI_CAPTURE_DECIMATE_EN
    input  logic [1:0]             i_cfg_decimate,
`endif
    hdmi_capture_ctrl_if.master    fifo_if,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_overflow,
    output logic                   o_sync_lost,
    output logic [FRAME_CNT_W-1:0] o_frame_count
);
    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [X_W-1:0]         r_x_off;
    logic [Y_W-1:0]         r_y_off;
    logic [X_W-1:0]         r_width;
    logic [Y_W-1:0]         r_height;
    logic                   r_cont;
    logic [1:0]             r_dec;
    logic [1:0]             w_dec_in;
    logic [DATA_W-1:0]      r_fifo_data;
    logic                   r_fifo_wr_en;
    logic                   r_busy;
    logic                   r_frame_done;
    logic                   r_overflow;
    logic                   r_sync_lost;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic                   w_start_ok;
    logic                   w_arm;
    logic                   w_vsync_rise;
    logic                   w_wr_sel;
    logic                   w_last_px;
    logic                   w_wr_cand;
    logic                   w_sync_loss;
    logic                   w_frame_end;

`ifdef HDMI_CAPTURE_DECIMATE_EN
    assign w_dec_in = i_cfg_decimate;
`else
    assign w_dec_in = 2'b00;
`endif

    hdmi_window_cnt #(.X_W(X_W), .Y_W(Y_W)) u_window_cnt (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clr        ((r_state != ST_CAPTURE) || w_vsync_rise),
        .i_de         (i_de),
        .i_vsync      (i_vsync),
        .i_x_off      (r_x_off),
        .i_y_off      (r_y_off),
        .i_width      (r_width),
        .i_height     (r_height),
        .i_dec        (r_dec),
        .o_vsync_rise (w_vsync_rise),
        .o_wr_sel     (w_wr_sel),
        .o_last_px    (w_last_px)
    );

    assign w_start_ok  = i_start && (i_cfg_width != '0) && (i_cfg_height != '0);
    assign w_arm       = (r_state == ST_IDLE) && w_start_ok && !i_abort;
    assign w_wr_cand   = (r_state == ST_CAPTURE) && w_wr_sel && i_hdmi_ready && !i_abort;
    assign w_sync_loss = !i_abort && !i_hdmi_ready &&
                         ((r_state == ST_WAIT_FRAME) || (r_state == ST_CAPTURE) || (r_state == ST_DONE));
    assign w_frame_end = (r_state == ST_DONE) && !i_abort;

    // Next-state logic; abort overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:       if (w_start_ok) w_state_nxt = ST_WAIT_READY; else w_state_nxt = ST_IDLE;
                ST_WAIT_READY: if (i_hdmi_ready) w_state_nxt = ST_WAIT_FRAME; else w_state_nxt = ST_WAIT_READY;
                ST_WAIT_FRAME: if (!i_hdmi_ready) w_state_nxt = ST_WAIT_READY;
                               else if (w_vsync_rise) w_state_nxt = ST_CAPTURE;
                               else w_state_nxt = ST_WAIT_FRAME;
                ST_CAPTURE:    if (!i_hdmi_ready) w_state_nxt = ST_WAIT_READY;
                               else if (w_vsync_rise) w_state_nxt = ST_CAPTURE;
                               else if (w_last_px) w_state_nxt = ST_DONE;
                               else w_state_nxt = ST_CAPTURE;
                ST_DONE:       if (!i_hdmi_ready) w_state_nxt = ST_WAIT_READY;
                               else if (r_cont) w_state_nxt = ST_WAIT_FRAME;
                               else w_state_nxt = ST_IDLE;
                default:       w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, latched configuration, write path and status flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_x_off       <= '0;
            r_y_off       <= '0;
            r_width       <= '0;
            r_height      <= '0;
            r_cont        <= 1'b0;
            r_dec         <= 2'b00;
            r_fifo_data   <= '0;
            r_fifo_wr_en  <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overflow    <= 1'b0;
            r_sync_lost   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_frame_done <= w_frame_end;
            if (w_arm) begin
                r_x_off  <= i_cfg_x_off;
                r_y_off  <= i_cfg_y_off;
                r_width  <= i_cfg_width;
                r_height <= i_cfg_height;
                r_cont   <= i_continuous;
                r_dec    <= w_dec_in;
            end
            if (w_wr_cand && !fifo_if.fifo_full) begin
                r_fifo_data  <= i_pix_data;
                r_fifo_wr_en <= 1'b1;
            end else begin
                r_fifo_wr_en <= 1'b0;
            end
            if (w_wr_cand && fifo_if.fifo_full) r_overflow <= 1'b1;
            else if (w_arm)                     r_overflow <= 1'b0;
            if (w_sync_loss)                    r_sync_lost <= 1'b1;
            else if (w_arm)                     r_sync_lost <= 1'b0;
            if (w_arm)                          r_frame_count <= '0;
            else if (w_frame_end)               r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
        end
    end

    assign fifo_if.fifo_data  = r_fifo_data;
    assign fifo_if.fifo_wr_en = r_fifo_wr_en;
    assign o_busy             = r_busy;
    assign o_frame_done       = r_frame_done;
    assign o_overflow         = r_overflow;
    assign o_sync_lost        = r_sync_lost;
    assign o_frame_count      = r_frame_count;
endmodule
